// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button/switch front end: channel map, timing
// defaults for the 80 MHz fast clock, and the repeat FSM state type.
package btn_conditioner_pkg;

    localparam int CLK_HZ      = 80_000_000;
    localparam int NCH_DEFAULT = 8;

    localparam int BTN_U    = 0;
    localparam int BTN_D    = 1;
    localparam int BTN_L    = 2;
    localparam int BTN_R    = 3;
    localparam int BTN_C    = 4;
    localparam int SW_START = 5;
    localparam int SW_MTM   = 6;
    localparam int SW_RST   = 7;

    // 10 ms debounce, 300 ms first repeat, 100 ms repeat period
    localparam int DB_TICKS_DEFAULT      = CLK_HZ / 100;
    localparam int REPEAT_DELAY_DEFAULT  = (CLK_HZ / 10) * 3;
    localparam int REPEAT_PERIOD_DEFAULT = CLK_HZ / 10;

    // Auto-repeat only on the direction/centre buttons, never on switches
    localparam logic [63:0] REPEAT_MASK_DEFAULT =
        (64'd1 << BTN_U) | (64'd1 << BTN_D) | (64'd1 << BTN_L) |
        (64'd1 << BTN_R) | (64'd1 << BTN_C);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Pin-side and game-side signals of the button front end; the conditioner
// is the slave (consumes raw pins), game logic or a bench is the master.
interface btn_conditioner_if
    import btn_conditioner_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT
);
    logic [NCH-1:0] raw;
    logic [NCH-1:0] level;
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic [NCH-1:0] rpt;
    logic [NCH-1:0] held;

    modport master (output raw, input level, press, rel, rpt, held);
    modport slave  (input raw, output level, press, rel, rpt, held);
endinterface

// File: rtl/btn_conditioner_channel.sv
// One channel: two-flop synchroniser, stability-count debounce, registered
// press/release ticks and an optional hold-to-repeat FSM.
module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter int DB_TICKS      = 4,
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_PERIOD = 3,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic rel_o,
    output logic rpt_o,
    output logic held_o
);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] dc_q, dc_d;
    logic [CNT_W-1:0] rc_q;
    logic             press_q, rel_q, rpt_q, held_q;
    rpt_state_e       state_q;
    logic             rise, fall;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        dc_d    = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (dc_q == CNT_W'(DB_TICKS - 1)) begin
                level_d = ~level_q;
            end else begin
                dc_d = dc_q + CNT_W'(1);
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            dc_q    <= '0;
            rc_q    <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
            held_q  <= 1'b0;
            state_q <= RPT_IDLE;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            dc_q    <= dc_d;
            press_q <= rise;
            rel_q   <= fall;
            // NOTE: non-blocking default here; a later assignment in the case below overrides it for this edge.
            rpt_q   <= 1'b0;

            // Release is judged on level_d so a repeat due on the release edge is dropped
            unique case (state_q)
                RPT_IDLE: begin
                    rc_q   <= '0;
                    held_q <= 1'b0;
                    if (rise) begin
                        rpt_q <= 1'b1;
                        if (REPEAT_EN) state_q <= RPT_DELAY;
                    end
                end
                RPT_DELAY: begin
                    if (!level_d) begin
                        state_q <= RPT_IDLE;
                        rc_q    <= '0;
                        held_q  <= 1'b0;
                    end else if (rc_q == CNT_W'(REPEAT_DELAY - 1)) begin
                        rpt_q   <= 1'b1;
                        held_q  <= 1'b1;
                        rc_q    <= '0;
                        state_q <= RPT_REPEAT;
                    end else begin
                        rc_q <= rc_q + CNT_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (!level_d) begin
                        state_q <= RPT_IDLE;
                        rc_q    <= '0;
                        held_q  <= 1'b0;
                    end else if (rc_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                        rpt_q <= 1'b1;
                        rc_q  <= '0;
                    end else begin
                        rc_q <= rc_q + CNT_W'(1);
                    end
                end
                default: state_q <= RPT_IDLE;
            endcase
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
    assign rel_o   = rel_q;
    assign rpt_o   = rpt_q;
    assign held_o  = held_q;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel button/switch front end for the fast clock domain: one
// independent btn_channel per pin, repeat enabled per bit of REPEAT_MASK.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int          NCH           = NCH_DEFAULT,
    parameter int          DB_TICKS      = DB_TICKS_DEFAULT,
    parameter int          REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int          REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
    parameter logic [63:0] REPEAT_MASK   = REPEAT_MASK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_conditioner_if.slave     bus
);

    localparam int CNT_W = $clog2(max3(DB_TICKS, REPEAT_DELAY, REPEAT_PERIOD) + 1);

    if (NCH < 1 || NCH > 64 || DB_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        (REPEAT_MASK >> NCH) != 64'd0) begin : g_param_err
        $error("btn_conditioner: counts must be >= 1 and REPEAT_MASK must fit in NCH bits");
    end

    logic [NCH-1:0] level_w, press_w, rel_w, rpt_w, held_w;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        btn_channel #(
            .DB_TICKS      (DB_TICKS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[i]),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (bus.raw[i]),
            .level_o (level_w[i]),
            .press_o (press_w[i]),
            .rel_o   (rel_w[i]),
            .rpt_o   (rpt_w[i]),
            .held_o  (held_w[i])
        );
    end

    assign bus.level = level_w;
    assign bus.press = press_w;
    assign bus.rel   = rel_w;
    assign bus.rpt   = rpt_w;
    assign bus.held  = held_w;

endmodule
